// File: rtl/fetch_buffer_pkg.sv
// Shared types and defaults for the instruction fetch buffer that sits
// between the fetch stage and decode.
package fetch_buffer_pkg;

  localparam int FB_DEFAULT_N     = 64;
  localparam int FB_DEFAULT_IW    = 32;
  localparam int FB_DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [FB_DEFAULT_N-1:0]  pc;
    logic [FB_DEFAULT_IW-1:0] instr;
  } fb_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small in-order FIFO of {pc, instr} pairs between fetch and decode, with a
// flush that discards all buffered entries on branch/trap.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int N     = FB_DEFAULT_N,
  parameter int IW    = FB_DEFAULT_IW,
  parameter int DEPTH = FB_DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [N-1:0]             in_pc,
  input  logic [IW-1:0]            in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [N-1:0]             out_pc,
  output logic [IW-1:0]            out_instr,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [N-1:0]  pc;
    logic [IW-1:0] instr;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // Handshake status derives only from registered occupancy, so a full
  // buffer never accepts even when decode pops in the same cycle.
  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != {CNT_W{1'b0}});
  assign count     = count_q;

  always_comb begin
    push = in_valid && in_ready && !flush;
    pop  = out_valid && out_ready && !flush;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      // Pointers are exactly log2(DEPTH) wide, so the increment wraps to 0.
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end else begin
        tail_d = tail_q;
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end else begin
        head_d = head_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left unreset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= '{pc: in_pc, instr: in_instr};
    end
  end

  always_comb begin
    if (out_valid) begin
      out_pc    = mem_q[head_q].pc;
      out_instr = mem_q[head_q].instr;
    end else begin
      out_pc    = {N{1'b0}};
      out_instr = {IW{1'b0}};
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed, table-driven bench for fetch_buffer with default parameters.
module tb_fetch_buffer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;

  int n_checks;
  int n_fail;

  fetch_buffer #(.N(64), .IW(32), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [63:0] pc;
    logic [31:0] ins;
    logic        ordy;
    logic        fl;
    logic [2:0]  e_cnt;
    logic        e_ir;
    logic        e_ov;
    logic [63:0] e_pc;
    logic [31:0] e_ins;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(logic iv, logic [63:0] pc, logic [31:0] ins,
                              logic ordy, logic fl, logic [2:0] c, logic ir,
                              logic ov, logic [63:0] epc, logic [31:0] eins);
    vec_t v;
    v.iv = iv; v.pc = pc; v.ins = ins; v.ordy = ordy; v.fl = fl;
    v.e_cnt = c; v.e_ir = ir; v.e_ov = ov; v.e_pc = epc; v.e_ins = eins;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] c, input logic ir,
                         input logic ov, input logic [63:0] pc, input logic [31:0] ins);
    chk({tag, ".count"},     64'(count),     64'(c));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(ir));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
    chk({tag, ".out_pc"},    out_pc,         pc);
    chk({tag, ".out_instr"}, 64'(out_instr), 64'(ins));
  endtask

  task automatic drive(input logic iv, input logic [63:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

    // Fill: four pushes, no pops; then a push attempt while full.
    vecs[0]  = mk(1'b1, 64'h0,  32'h13,  1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 64'h0,  32'h13);
    vecs[1]  = mk(1'b1, 64'h4,  32'h93,  1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 64'h0,  32'h13);
    vecs[2]  = mk(1'b1, 64'h8,  32'h113, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 64'h0,  32'h13);
    vecs[3]  = mk(1'b1, 64'hC,  32'h193, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 64'h0,  32'h13);
    vecs[4]  = mk(1'b1, 64'h10, 32'h213, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 64'h0,  32'h13);
    // Pop while full with in_valid held: no pop-through.
    vecs[5]  = mk(1'b1, 64'h10, 32'h213, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 64'h4,  32'h93);
    vecs[6]  = mk(1'b0, 64'h0,  32'h0,   1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 64'h8,  32'h113);
    // Simultaneous push/pop at count=2, then drain across the head wrap.
    vecs[7]  = mk(1'b1, 64'h20, 32'h213, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 64'hC,  32'h193);
    vecs[8]  = mk(1'b1, 64'h24, 32'h293, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 64'hC,  32'h193);
    vecs[9]  = mk(1'b0, 64'h0,  32'h0,   1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 64'h20, 32'h213);
    vecs[10] = mk(1'b0, 64'h0,  32'h0,   1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 64'h24, 32'h293);
    vecs[11] = mk(1'b0, 64'h0,  32'h0,   1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 64'h0,  32'h0);
    // Refill across the tail wrap, then flush with a same-cycle push.
    vecs[12] = mk(1'b1, 64'h30, 32'h313, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 64'h30, 32'h313);
    vecs[13] = mk(1'b1, 64'h34, 32'h393, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 64'h30, 32'h313);
    vecs[14] = mk(1'b1, 64'h38, 32'h413, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 64'h30, 32'h313);
    vecs[15] = mk(1'b1, 64'h40, 32'h513, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 64'h0,  32'h0);
    vecs[16] = mk(1'b0, 64'h0,  32'h0,   1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 64'h0,  32'h0);
    vecs[17] = mk(1'b1, 64'h44, 32'h593, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 64'h44, 32'h593);
    vecs[18] = mk(1'b1, 64'h48, 32'h613, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 64'h44, 32'h593);

    #12;
    chk_out("in_reset", 3'd0, 1'b1, 1'b0, 64'h0, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk_out("post_reset", 3'd0, 1'b1, 1'b0, 64'h0, 32'h0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].iv, vecs[i].pc, vecs[i].ins, vecs[i].ordy, vecs[i].fl);
      @(posedge clk); #1;
      chk_out($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_ir, vecs[i].e_ov,
              vecs[i].e_pc, vecs[i].e_ins);
    end

    // Asynchronous reset mid-cycle with count=2: effect before the next edge.
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_reset", 3'd0, 1'b1, 1'b0, 64'h0, 32'h0);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk_out("after_async_reset", 3'd0, 1'b1, 1'b0, 64'h0, 32'h0);

    // No empty bypass: a push into an empty buffer is invisible until the edge.
    drive(1'b1, 64'h50, 32'h693, 1'b0, 1'b0);
    #1;
    chk_out("no_bypass", 3'd0, 1'b1, 1'b0, 64'h0, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    chk_out("bypass_edge", 3'd1, 1'b1, 1'b1, 64'h50, 32'h693);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
